// File: rtl/m6809_bus_arbiter.sv
// m6809_bus_arbiter: single-port memory bus controller for the 6809 SoC.
// Arbitrates the shared bus between the CPU core and a DMA/debug requester
// (round-robin on ties), decodes the granted address into RAM/IO/ROM/unmapped,
// inserts per-region wait states and returns read data with a one-cycle ack.
// Region selects and the write enable cover exactly the ACCESS cycles; the
// DONE cycle only carries the ack (and bus_err) back to the winner.
module m6809_bus_arbiter #(
  parameter int unsigned ROM_WAIT = 0,
  parameter int unsigned RAM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset_b,
  // CPU core port
  input  logic        core_req,
  input  logic [15:0] core_addr,
  input  logic        core_rw_n,
  input  logic [7:0]  core_wdata,
  output logic        core_ack,
  output logic [7:0]  core_rdata,
  // DMA / debug port
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic        dma_rw_n,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  // Memory side
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_sel_rom,
  output logic        mem_sel_ram,
  output logic        mem_sel_io,
  input  logic [7:0]  mem_rdata_rom,
  input  logic [7:0]  mem_rdata_ram,
  input  logic [7:0]  mem_rdata_io,
  output logic        bus_err
);

  localparam logic [2:0] ROM_W = 3'(ROM_WAIT);
  localparam logic [2:0] RAM_W = 3'(RAM_WAIT);
  localparam logic [2:0] IO_W  = 3'(IO_WAIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    R_RAM   = 2'd0,
    R_IO    = 2'd1,
    R_ROM   = 2'd2,
    R_UNMAP = 2'd3
  } region_t;

  // Memory map: RAM 0000-7FFF, unmapped 8000-DFFF, IO E000-EFFF, ROM F000-FFFF.
  function automatic region_t decode_region(input logic [15:0] a);
    region_t r;
    if (!a[15])                 r = R_RAM;
    else if (a[15:12] == 4'hF)  r = R_ROM;
    else if (a[15:12] == 4'hE)  r = R_IO;
    else                        r = R_UNMAP;
    return r;
  endfunction

  // Unmapped accesses complete without extra wait states.
  function automatic logic [2:0] region_wait(input region_t r);
    logic [2:0] w;
    case (r)
      R_ROM:   w = ROM_W;
      R_RAM:   w = RAM_W;
      R_IO:    w = IO_W;
      default: w = 3'd0;
    endcase
    return w;
  endfunction

  state_t      state_q;
  region_t     region_q;
  logic        grant_dma_q;
  logic        last_grant_dma_q;
  logic        rw_n_q;
  logic [2:0]  wait_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic        mem_we_q;
  logic        sel_rom_q;
  logic        sel_ram_q;
  logic        sel_io_q;
  logic        core_ack_q;
  logic        dma_ack_q;
  logic [7:0]  core_rdata_q;
  logic [7:0]  dma_rdata_q;
  logic        bus_err_q;

  logic        grant_dma_d;
  logic [15:0] addr_d;
  logic        rw_n_d;
  logic [7:0]  wdata_d;
  region_t     region_d;
  logic [7:0]  rdata_d;

  // Arbitration and request mux: a tie goes to whoever did not win last time.
  always_comb begin
    grant_dma_d = 1'b0;
    if (dma_req && !core_req) begin
      grant_dma_d = 1'b1;
    end else if (dma_req && core_req) begin
      grant_dma_d = last_grant_dma_q ? 1'b0 : 1'b1;
    end
    addr_d   = grant_dma_d ? dma_addr  : core_addr;
    rw_n_d   = grant_dma_d ? dma_rw_n  : core_rw_n;
    wdata_d  = grant_dma_d ? dma_wdata : core_wdata;
    region_d = decode_region(addr_d);
  end

  // Read-data mux for the region being accessed; unmapped space reads as FF.
  always_comb begin
    rdata_d = 8'hFF;
    case (region_q)
      R_ROM:   rdata_d = mem_rdata_rom;
      R_RAM:   rdata_d = mem_rdata_ram;
      R_IO:    rdata_d = mem_rdata_io;
      default: rdata_d = 8'hFF;
    endcase
  end

  // Bus FSM: IDLE grants, ACCESS counts wait states, DONE carries the ack.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q          <= S_IDLE;
      region_q         <= R_RAM;
      grant_dma_q      <= 1'b0;
      last_grant_dma_q <= 1'b1;
      rw_n_q           <= 1'b1;
      wait_q           <= 3'd0;
      mem_addr_q       <= 16'h0000;
      mem_wdata_q      <= 8'h00;
      mem_we_q         <= 1'b0;
      sel_rom_q        <= 1'b0;
      sel_ram_q        <= 1'b0;
      sel_io_q         <= 1'b0;
      core_ack_q       <= 1'b0;
      dma_ack_q        <= 1'b0;
      core_rdata_q     <= 8'h00;
      dma_rdata_q      <= 8'h00;
      bus_err_q        <= 1'b0;
    end else begin
      // Ack and bus_err are single-cycle pulses.
      core_ack_q <= 1'b0;
      dma_ack_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (core_req || dma_req) begin
            grant_dma_q      <= grant_dma_d;
            last_grant_dma_q <= grant_dma_d;
            mem_addr_q       <= addr_d;
            mem_wdata_q      <= wdata_d;
            rw_n_q           <= rw_n_d;
            region_q         <= region_d;
            sel_rom_q        <= (region_d == R_ROM);
            sel_ram_q        <= (region_d == R_RAM);
            sel_io_q         <= (region_d == R_IO);
            mem_we_q         <= !rw_n_d && ((region_d == R_RAM) || (region_d == R_IO));
            wait_q           <= region_wait(region_d);
            state_q          <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (wait_q != 3'd0) begin
            wait_q <= wait_q - 3'd1;
          end else begin
            if (grant_dma_q) begin
              dma_rdata_q <= rdata_d;
              dma_ack_q   <= 1'b1;
            end else begin
              core_rdata_q <= rdata_d;
              core_ack_q   <= 1'b1;
            end
            bus_err_q <= (region_q == R_UNMAP) || ((region_q == R_ROM) && !rw_n_q);
            sel_rom_q <= 1'b0;
            sel_ram_q <= 1'b0;
            sel_io_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign core_ack    = core_ack_q;
  assign core_rdata  = core_rdata_q;
  assign dma_ack     = dma_ack_q;
  assign dma_rdata   = dma_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_sel_rom = sel_rom_q;
  assign mem_sel_ram = sel_ram_q;
  assign mem_sel_io  = sel_io_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_m6809_bus_arbiter.sv
// Testbench for m6809_bus_arbiter (ROM_WAIT=0, RAM_WAIT=0, IO_WAIT=2).
// Table of single accesses plus hand sequences for round-robin ties and
// reset in the middle of an IO access; completions checked via a scoreboard.
module tb_m6809_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_b;
  logic        core_req, core_rw_n, core_ack;
  logic [15:0] core_addr;
  logic [7:0]  core_wdata, core_rdata;
  logic        dma_req, dma_rw_n, dma_ack;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata, dma_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_sel_rom, mem_sel_ram, mem_sel_io, bus_err;
  logic [7:0]  mem_rdata_rom, mem_rdata_ram, mem_rdata_io;

  m6809_bus_arbiter #(.ROM_WAIT(0), .RAM_WAIT(0), .IO_WAIT(2)) dut (
    .clk(clk), .reset_b(reset_b),
    .core_req(core_req), .core_addr(core_addr), .core_rw_n(core_rw_n),
    .core_wdata(core_wdata), .core_ack(core_ack), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_rw_n(dma_rw_n),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_sel_rom(mem_sel_rom), .mem_sel_ram(mem_sel_ram), .mem_sel_io(mem_sel_io),
    .mem_rdata_rom(mem_rdata_rom), .mem_rdata_ram(mem_rdata_ram), .mem_rdata_io(mem_rdata_io),
    .bus_err(bus_err)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of completions expected, in order.
  typedef struct {
    logic       is_dma;
    logic [7:0] rdata;
    logic       err;
  } sb_t;
  sb_t sb_q[$];
  logic [7:0] model_core_rdata;
  logic [7:0] model_dma_rdata;

  // One access vector: inputs plus expected bus behaviour and result.
  typedef struct {
    logic        is_dma;
    logic [15:0] addr;
    logic        rw_n;
    logic [7:0]  wdata;
    logic [7:0]  rom_d, ram_d, io_d;
    logic [2:0]  exp_sel;   // {rom, ram, io}
    logic        exp_we;
    logic [7:0]  exp_rdata;
    logic        exp_err;
    int          exp_wait;
  } vec_t;
  vec_t vecs[16];

  function automatic logic [63:0] all_outs();
    return 64'({core_ack, dma_ack, bus_err, mem_we, mem_sel_rom, mem_sel_ram, mem_sel_io,
                mem_addr, mem_wdata, core_rdata, dma_rdata});
  endfunction

  // Compare an observed ack against the head of the scoreboard.
  task automatic sb_compare();
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected_ack: core_ack=%0b dma_ack=%0b, required no ack", core_ack, dma_ack);
      return;
    end
    e = sb_q.pop_front();
    check("ack_port", {core_ack, dma_ack}, e.is_dma ? 2'b01 : 2'b10);
    check("bus_err", bus_err, e.err);
    if (e.is_dma) begin
      check("dma_rdata", dma_rdata, e.rdata);
      check("core_rdata_kept", core_rdata, model_core_rdata);
      model_dma_rdata = e.rdata;
    end else begin
      check("core_rdata", core_rdata, e.rdata);
      check("dma_rdata_kept", dma_rdata, model_dma_rdata);
      model_core_rdata = e.rdata;
    end
  endtask

  task automatic wait_ack(input int bound, output logic got);
    got = 1'b0;
    for (int c = 0; c < bound && !got; c++) begin
      @(negedge clk);
      if (core_ack || dma_ack) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: no ack within %0d cycles, required one", bound);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   n;
    logic got, held_ok;
    @(negedge clk);
    mem_rdata_rom = v.rom_d;
    mem_rdata_ram = v.ram_d;
    mem_rdata_io  = v.io_d;
    if (v.is_dma) begin
      dma_req = 1'b1; dma_addr = v.addr; dma_rw_n = v.rw_n; dma_wdata = v.wdata;
    end else begin
      core_req = 1'b1; core_addr = v.addr; core_rw_n = v.rw_n; core_wdata = v.wdata;
    end
    sb_q.push_back('{v.is_dma, v.exp_rdata, v.exp_err});
    @(negedge clk);
    check($sformatf("v%0d_sel", idx), {mem_sel_rom, mem_sel_ram, mem_sel_io}, v.exp_sel);
    check($sformatf("v%0d_addr", idx), mem_addr, v.addr);
    check($sformatf("v%0d_we", idx), mem_we, v.exp_we);
    if (!v.rw_n) check($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
    n = 0; got = 1'b0; held_ok = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      if (c > 0) @(negedge clk);
      if (core_ack || dma_ack) begin
        got = 1'b1;
      end else begin
        n++;
        if ({mem_sel_rom, mem_sel_ram, mem_sel_io} !== v.exp_sel || mem_we !== v.exp_we) held_ok = 1'b0;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL v%0d_ack_timeout: no ack within 20 cycles, required one", idx);
    end else begin
      check($sformatf("v%0d_access_cycles", idx), n, v.exp_wait + 1);
      check($sformatf("v%0d_held", idx), held_ok, 1'b1);
      sb_compare();
      check($sformatf("v%0d_sel_clear", idx), {mem_sel_rom, mem_sel_ram, mem_sel_io, mem_we}, 4'b0000);
    end
    core_req = 1'b0;
    dma_req  = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_pulse_end", idx), {core_ack, dma_ack, bus_err}, 3'b000);
  endtask

  initial begin
    logic got;
    int   t_prev;
    logic seen;
    logic [15:0] exp_addr;

    //                  dma   addr    rw_n  wdata  rom    ram    io     sel     we    rdata  err  W
    vecs[0]  = '{1'b0, 16'hFFFE, 1'b1, 8'h00, 8'h80, 8'h3C, 8'h5A, 3'b100, 1'b0, 8'h80, 1'b0, 0};
    vecs[1]  = '{1'b0, 16'h1234, 1'b0, 8'h55, 8'h81, 8'h3D, 8'h5B, 3'b010, 1'b1, 8'h3D, 1'b0, 0};
    vecs[2]  = '{1'b0, 16'hF000, 1'b0, 8'hAA, 8'h77, 8'h21, 8'h42, 3'b100, 1'b0, 8'h77, 1'b1, 0};
    vecs[3]  = '{1'b0, 16'h9000, 1'b1, 8'h00, 8'h10, 8'h20, 8'h30, 3'b000, 1'b0, 8'hFF, 1'b1, 0};
    vecs[4]  = '{1'b1, 16'hE001, 1'b1, 8'h00, 8'h01, 8'h02, 8'hA5, 3'b001, 1'b0, 8'hA5, 1'b0, 2};
    vecs[5]  = '{1'b1, 16'hE0FF, 1'b0, 8'h12, 8'h03, 8'h04, 8'h5C, 3'b001, 1'b1, 8'h5C, 1'b0, 2};
    vecs[6]  = '{1'b0, 16'h7FFF, 1'b1, 8'h00, 8'h44, 8'h11, 8'h66, 3'b010, 1'b0, 8'h11, 1'b0, 0};
    vecs[7]  = '{1'b1, 16'h8000, 1'b1, 8'h00, 8'h12, 8'h34, 8'h56, 3'b000, 1'b0, 8'hFF, 1'b1, 0};
    vecs[8]  = '{1'b0, 16'hDFFF, 1'b1, 8'h00, 8'h9A, 8'hBC, 8'hDE, 3'b000, 1'b0, 8'hFF, 1'b1, 0};
    vecs[9]  = '{1'b1, 16'hEFFF, 1'b1, 8'h00, 8'hC1, 8'hC2, 8'hC3, 3'b001, 1'b0, 8'hC3, 1'b0, 2};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 8'h00, 8'hE5, 8'hE7, 8'hE9, 3'b010, 1'b0, 8'hE7, 1'b0, 0};
    vecs[11] = '{1'b1, 16'h9000, 1'b0, 8'h34, 8'h0F, 8'h1F, 8'h2F, 3'b000, 1'b0, 8'hFF, 1'b1, 0};
    vecs[12] = '{1'b1, 16'hFFF0, 1'b0, 8'h99, 8'h2D, 8'h3E, 8'h4F, 3'b100, 1'b0, 8'h2D, 1'b1, 0};
    vecs[13] = '{1'b0, 16'hE000, 1'b1, 8'h00, 8'h60, 8'h61, 8'h6B, 3'b001, 1'b0, 8'h6B, 1'b0, 2};
    vecs[14] = '{1'b1, 16'hFFFF, 1'b1, 8'h00, 8'hF1, 8'hF2, 8'hF3, 3'b100, 1'b0, 8'hF1, 1'b0, 0};
    vecs[15] = '{1'b1, 16'h7000, 1'b0, 8'hC8, 8'h50, 8'h51, 8'h52, 3'b010, 1'b1, 8'h51, 1'b0, 0};

    reset_b = 1'b0;
    core_req = 1'b0; core_addr = 16'h0; core_rw_n = 1'b1; core_wdata = 8'h0;
    dma_req  = 1'b0; dma_addr  = 16'h0; dma_rw_n  = 1'b1; dma_wdata  = 8'h0;
    mem_rdata_rom = 8'h00; mem_rdata_ram = 8'h00; mem_rdata_io = 8'h00;
    model_core_rdata = 8'h00;
    model_dma_rdata  = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 64'h0);
    reset_b = 1'b1;

    // Single accesses from the table
    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Continuous tie from reset: core, dma, core, dma, 3 cycles apart
    @(negedge clk);
    reset_b = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    model_core_rdata = 8'h00;
    model_dma_rdata  = 8'h00;
    mem_rdata_ram = 8'h4D;
    core_req = 1'b1; core_addr = 16'h0100; core_rw_n = 1'b1;
    dma_req  = 1'b1; dma_addr  = 16'h0200; dma_rw_n  = 1'b1;
    for (int g = 0; g < 4; g++) sb_q.push_back('{(g % 2) == 1, 8'h4D, 1'b0});
    t_prev = 0;
    for (int g = 0; g < 4; g++) begin
      wait_ack(10, got);
      if (got) begin
        exp_addr = ((g % 2) == 1) ? 16'h0200 : 16'h0100;
        check($sformatf("rr%0d_addr", g), mem_addr, exp_addr);
        sb_compare();
        if (g > 0) check($sformatf("rr%0d_period", g), cyc - t_prev, 3);
        t_prev = cyc;
      end
    end
    core_req = 1'b0;
    dma_req  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during an IO wait cycle: abandoned access never acks
    mem_rdata_io = 8'h3A;
    core_req = 1'b1; core_addr = 16'hE001; core_rw_n = 1'b1;
    @(negedge clk);
    check("rst_mid_sel_io", mem_sel_io, 1'b1);
    @(negedge clk);
    reset_b = 1'b0;
    #1;
    check("rst_mid_outputs", all_outs(), 64'h0);
    core_req = 1'b0;
    model_core_rdata = 8'h00;
    model_dma_rdata  = 8'h00;
    @(negedge clk);
    reset_b = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (core_ack || dma_ack || bus_err) seen = 1'b1;
    end
    check("rst_mid_no_ack", seen, 1'b0);

    // First tie after reset goes to the core
    mem_rdata_ram = 8'h96;
    core_req = 1'b1; core_addr = 16'h0300; core_rw_n = 1'b1;
    dma_req  = 1'b1; dma_addr  = 16'h0400; dma_rw_n  = 1'b1;
    sb_q.push_back('{1'b0, 8'h96, 1'b0});
    sb_q.push_back('{1'b1, 8'h96, 1'b0});
    wait_ack(10, got);
    if (got) begin
      check("post_rst_core_addr", mem_addr, 16'h0300);
      sb_compare();
    end
    core_req = 1'b0;
    wait_ack(10, got);
    if (got) begin
      check("post_rst_dma_addr", mem_addr, 16'h0400);
      sb_compare();
    end
    dma_req = 1'b0;
    repeat (2) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
